cl_crc_stream: RTL and testbench
================================

// Module: cl_crc_stream
// PURPOSE
//  Parametrised streaming CRC engine for generation and checking in hardware.
//  - Consumes byte-oriented frames over a valid/ready beat interface, DATA_W bits per beat.
//  - Produces one CRC result per frame on a separate valid/ready result port.
//  - Generalises the software CRC model: any width/polynomial/reflection, multi-byte beats,
//    partial last beat, check mode with residue compare, back-pressure on the result.
// PARAMETERS
//  DATA_W   32            beat width in bits; multiple of 8, 8..128
//  CRC_W    32            CRC width in bits, 8..64
//  POLY     32'h04C11DB7  generator polynomial, normal form, implicit x^CRC_W
//  INIT     32'hFFFFFFFF  register preset at frame start
//  REFIN    1             1: each byte processed LSB first
//  REFOUT   1             1: final register bit-reversed before XOROUT
//  XOROUT   32'hFFFFFFFF  final XOR mask
//  CHECK    0             0: generate; 1: check (frame carries its CRC at the tail)
//  RESIDUE  32'h2144DF1C  expected crc_value of a good frame when CHECK=1
// PORTS
//  clk        in   1          clock
//  reset      in   1          asynchronous active-high reset
//  in_valid   in   1          beat valid
//  in_ready   out  1          beat accepted when in_valid & in_ready
//  in_data    in   DATA_W     beat; byte 0 = in_data[7:0], processed first
//  in_keep    in   DATA_W/8   byte enables; all-ones except on the last beat
//  in_last    in   1          last beat of frame
//  crc_valid  out  1          result valid
//  crc_ready  in   1          result consumed when crc_valid & crc_ready
//  crc_value  out  CRC_W      final CRC (after REFOUT, XOROUT)
//  crc_ok     out  1          CHECK=1: crc_value==RESIDUE; CHECK=0: constant 1
// BEHAVIOUR
//  - Reset (async assert, sync release to clk): state=IDLE, crc_reg=INIT, in_ready=1,
//    crc_valid=0, crc_value=0, crc_ok=0.
//  - FSM IDLE -> ACCUM on accepted beat with in_last=0.
//  - FSM IDLE/ACCUM -> DONE on accepted beat with in_last=1.
//  - FSM ACCUM holds while no beat is accepted.
//  - FSM DONE -> IDLE on crc_valid & crc_ready; crc_reg reloaded to INIT that same edge.
//  - in_ready = (state != DONE); no frame overlap; the next frame starts the cycle after the result pops.
//  - Per accepted beat: crc_reg advances over the enabled bytes in order 0..N-1.
//    - In one cycle, as an unrolled bitwise LFSR.
//    - Disabled bytes leave crc_reg unchanged.
//  - in_keep on the last beat must be contiguous from bit 0; all-zero is legal (no bytes added).
//    Non-contiguous keep, or keep != all-ones on a non-last beat, is a protocol error.
//    - No error output is generated for it.
//    - The result is undefined; the FSM still advances normally.
//  - Latency: crc_valid rises the cycle after the last beat is accepted.
//    - crc_value and crc_ok are registered and stable while crc_valid=1 and crc_ready=0.
//  - crc_value = (REFOUT ? bitrev(crc_reg) : crc_reg) ^ XOROUT[CRC_W-1:0].
//  - Parameters wider than CRC_W are truncated to their low CRC_W bits.
//  - in_valid=0 mid-frame: bubble; state and crc_reg hold.
//  - Single-beat frame: IDLE -> DONE directly.
//  - crc_ready may be high before crc_valid; it has no effect outside DONE.
//  - Reset mid-frame or in DONE: partial frame and pending result are discarded.
//    - crc_valid drops immediately on reset assertion.
// TESTING
//  - CRC-32 defaults, DATA_W=32, frame "123456789" as 34333231/38373635/00000039, keep 1111/1111/0001
//    -> crc_value=CBF43926, one cycle after the last beat.
//  - CRC_W=16, POLY=1021, INIT=FFFF, REFIN=REFOUT=0, XOROUT=0, same frame -> crc_value=29B1.
//  - CHECK=1, frame "123456789" plus tail bytes 26 39 F4 CB -> crc_ok=1, crc_value=2144DF1C.
//    - Flip one data bit -> crc_ok=0.
//  - crc_ready=0 for 5 cycles after crc_valid -> crc_valid and crc_value hold, in_ready=0.
//    - A second frame waits and then yields CBF43926 again.
//  - Random in_valid bubbles (50%), and a last beat with keep=0000 -> result identical to the gap-free frame.
//  - Assert reset after beat 1 of 3, then resend the full frame -> CBF43926.
//    - No stale crc_valid during or after reset.

Source files
------------

// File: rtl/cl_crc_stream.sv
// cl_crc_stream -- streaming CRC engine, one result per frame.
//
// Bytes arrive DATA_W/8 at a time on a valid/ready beat port. Byte 0
// (in_data[7:0]) is folded into the CRC first. Only bytes with their in_keep
// bit set are folded in; the rest are skipped. A beat with in_last=1 closes
// the frame. The finished CRC is then held on the result port until it is
// popped. No new beat is accepted while a result is waiting.
//
// The CRC register is kept in normal (MSB-first) form. The choices below are
// all parameters:
//   - REFIN picks LSB-first or MSB-first bit order inside each byte.
//   - REFOUT bit-reverses the register before the XOROUT mask is applied.
//   - CHECK=1 compares the finished value against RESIDUE. This is for frames
//     that carry their own CRC at the tail.
// Wide parameters are truncated to their low CRC_W bits.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   in_valid   beat valid
//   in_ready   beat accepted when in_valid & in_ready (low while a result waits)
//   in_data    beat data, byte 0 in bits [7:0]
//   in_keep    byte enables, contiguous from bit 0 on the last beat
//   in_last    last beat of the frame
//   crc_valid  result valid
//   crc_ready  result consumed when crc_valid & crc_ready
//   crc_value  final CRC after REFOUT and XOROUT
//   crc_ok     CHECK=1: crc_value == RESIDUE; CHECK=0: 1
module cl_crc_stream #(
  parameter int          DATA_W  = 32,
  parameter int          CRC_W   = 32,
  parameter logic [63:0] POLY    = 64'h04C11DB7,
  parameter logic [63:0] INIT    = 64'hFFFFFFFF,
  parameter bit          REFIN   = 1'b1,
  parameter bit          REFOUT  = 1'b1,
  parameter logic [63:0] XOROUT  = 64'hFFFFFFFF,
  parameter bit          CHECK   = 1'b0,
  parameter logic [63:0] RESIDUE = 64'h2144DF1C
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                crc_valid,
  input  logic                crc_ready,
  output logic [CRC_W-1:0]    crc_value,
  output logic                crc_ok
);

  localparam int NB = DATA_W / 8;

  localparam logic [CRC_W-1:0] POLY_C    = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOROUT_C  = XOROUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RESIDUE_C = RESIDUE[CRC_W-1:0];

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] value_q, value_d;
  logic             ok_q, ok_d;

  logic [CRC_W-1:0] crc_beat;   // crc_q advanced over this beat's enabled bytes
  logic [CRC_W-1:0] crc_final;  // crc_beat after output reflection and mask

  // Advance the register by one byte, one LFSR step per bit.
  // The steps are unrolled, so a whole beat is folded in within one cycle.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c_in,
                                                input logic [7:0]       b);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[CRC_W-1] ^ (REFIN ? b[i] : b[7-i]);
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_C : '0);
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // Bytes are folded in order 0..NB-1.
  // A disabled byte passes the register through unchanged.
  always_comb begin
    crc_beat = crc_q;
    for (int k = 0; k < NB; k++) begin
      if (in_keep[k]) crc_beat = crc_byte(crc_beat, in_data[8*k +: 8]);
    end
    crc_final = (REFOUT ? bitrev(crc_beat) : crc_beat) ^ XOROUT_C;
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    value_d = value_q;
    ok_d    = ok_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (in_valid) begin
          crc_d = crc_beat;
          if (in_last) begin
            state_d = DONE;
            value_d = crc_final;
            ok_d    = CHECK ? (crc_final == RESIDUE_C) : 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        // Preset the register on the pop edge.
        // The next frame can then start on the very next cycle.
        if (crc_ready) begin
          state_d = IDLE;
          crc_d   = INIT_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= INIT_C;
      value_q <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      value_q <= value_d;
      ok_q    <= ok_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign crc_valid = (state_q == DONE);
  assign crc_value = value_q;
  assign crc_ok    = ok_q;

endmodule

// File: tb/tb_cl_crc_stream.sv
// Testbench for cl_crc_stream.
//
// Three instances share one input stream:
//   - a CRC-32 generator,
//   - a CRC-16/CCITT-FALSE generator,
//   - a CRC-32 checker.
// Expected results come from a polynomial long-division model of the whole
// frame.
module tb_cl_crc_stream;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_keep = '0;
  logic        in_last = 1'b0;
  logic        crc_ready = 1'b0;

  logic        rdy32, val32, ok32;
  logic [31:0] value32;
  logic        rdy16, val16, ok16;
  logic [15:0] value16;
  logic        rdyck, valck, okck;
  logic [31:0] valueck;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cl_crc_stream #(.DATA_W(32), .CRC_W(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .crc_valid(val32), .crc_ready(crc_ready), .crc_value(value32), .crc_ok(ok32));

  cl_crc_stream #(.DATA_W(32), .CRC_W(16), .POLY(64'h1021), .INIT(64'hFFFF),
                  .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(64'h0)) u16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .crc_valid(val16), .crc_ready(crc_ready), .crc_value(value16), .crc_ok(ok16));

  cl_crc_stream #(.DATA_W(32), .CRC_W(32), .CHECK(1'b1)) uck (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdyck),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .crc_valid(valck), .crc_ready(crc_ready), .crc_value(valueck), .crc_ok(okck));

  // Model: the register after n message bits equals
  // (INIT*x^n + M(x)*x^W) mod P, where M holds the bits in stream order.
  // The result then gets the optional reflection and the XOR mask.
  function automatic logic [63:0] ref_crc(input bq_t f, input int w,
                                          input logic [63:0] poly, input logic [63:0] init,
                                          input bit refin, input bit refout,
                                          input logic [63:0] xorout);
    int          n;
    bit          m[];
    logic [63:0] r;
    logic [63:0] mask;
    n = f.size() * 8;
    m = new[n + w];
    foreach (m[i]) m[i] = 1'b0;
    for (int i = 0; i < w; i++) m[n + i] = init[i];
    for (int k = 0; k < f.size(); k++)
      for (int j = 0; j < 8; j++)
        m[w + n - 1 - (8*k + j)] ^= refin ? f[k][j] : f[k][7-j];
    for (int p = n + w - 1; p >= w; p--)
      if (m[p])
        for (int i = 0; i <= w; i++) m[p - w + i] ^= (i == w) ? 1'b1 : poly[i];
    r = '0;
    for (int i = 0; i < w; i++) r[i] = refout ? m[w - 1 - i] : m[i];
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (r ^ xorout) & mask;
  endfunction

  function automatic logic [63:0] ref32(input bq_t f);
    return ref_crc(f, 32, 64'h04C11DB7, 64'hFFFFFFFF, 1'b1, 1'b1, 64'hFFFFFFFF);
  endfunction

  function automatic logic [63:0] ref16(input bq_t f);
    return ref_crc(f, 16, 64'h1021, 64'hFFFF, 1'b0, 1'b0, 64'h0);
  endfunction

  function automatic bq_t frame_123();
    bq_t f;
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    return f;
  endfunction

  // Present one beat and hold it until it is accepted.
  // On return the time is 1 unit after the accepting edge.
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (rdy32) begin
        @(posedge clk); #1;
        acc = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL beat_accept: in_ready=%0b never accepted beat, required accept within 50 cycles", rdy32);
    end
  endtask

  // Send a frame as 4-byte beats.
  // bubbles:     randomly idle in_valid between beats.
  // extra_empty: close the frame with an extra keep=0 last beat.
  task automatic send_frame(input bq_t f, input bit bubbles, input bit extra_empty);
    int nb;
    logic [31:0] d;
    logic [3:0]  k;
    bit          last;
    nb = (f.size() + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      if (bubbles && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0; in_data = $urandom; in_keep = 4'($urandom);
        @(posedge clk); #1;
      end
      d = '0; k = '0;
      for (int j = 0; j < 4; j++)
        if (4*b + j < f.size()) begin
          d[8*j +: 8] = f[4*b + j];
          k[j] = 1'b1;
        end
      last = (b == nb - 1) && !extra_empty;
      drive_beat(d, k, last);
    end
    if (extra_empty || nb == 0) begin
      if (bubbles && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0; @(posedge clk); #1;
      end
      drive_beat($urandom, 4'b0000, 1'b1);
    end
    checks++;
    if (val32 !== 1'b1 || valck !== 1'b1 || val16 !== 1'b1) begin
      errors++;
      $display("FAIL latency: crc_valid=%0b/%0b/%0b one cycle after last beat, required 1/1/1",
               val32, val16, valck);
    end
  endtask

  // Compare all three results against the model, then pop the result.
  task automatic check_and_pop(input bq_t f, input string name);
    logic [63:0] e32, e16;
    e32 = ref32(f);
    e16 = ref16(f);
    checks++;
    if (value32 !== e32[31:0]) begin
      errors++; $display("FAIL %s crc32: got %08h required %08h", name, value32, e32[31:0]);
    end
    checks++;
    if (value16 !== e16[15:0]) begin
      errors++; $display("FAIL %s crc16: got %04h required %04h", name, value16, e16[15:0]);
    end
    checks++;
    if (valueck !== e32[31:0] || okck !== (e32[31:0] == 32'h2144DF1C)) begin
      errors++; $display("FAIL %s check: value %08h ok %0b required %08h ok %0b",
                         name, valueck, okck, e32[31:0], (e32[31:0] == 32'h2144DF1C));
    end
    checks++;
    if (ok32 !== 1'b1 || ok16 !== 1'b1) begin
      errors++; $display("FAIL %s gen_ok: got %0b/%0b required 1/1", name, ok32, ok16);
    end
    crc_ready = 1'b1;
    @(posedge clk); #1;
    crc_ready = 1'b0;
    checks++;
    if (val32 !== 1'b0 || rdy32 !== 1'b1 || valck !== 1'b0) begin
      errors++; $display("FAIL %s pop: crc_valid=%0b in_ready=%0b required 0 1", name, val32, rdy32);
    end
    $display("frame %s: bytes=%0d crc32=%08h crc16=%04h ok=%0b", name, f.size(), value32, value16, okck);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    crc_ready = 1'b1;  // no effect outside DONE
    @(posedge clk); #1;
    checks++;
    if (val32 !== 1'b0 || rdy32 !== 1'b1 || value32 !== 32'h0 || ok32 !== 1'b0 ||
        value16 !== 16'h0 || okck !== 1'b0 || valueck !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b ready=%0b value=%08h ok=%0b required 0 1 00000000 0",
               val32, rdy32, value32, ok32);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    crc_ready = 1'b0;
    checks++;
    if (val32 !== 1'b0 || rdy32 !== 1'b1) begin
      errors++; $display("FAIL reset_release: valid=%0b ready=%0b required 0 1", val32, rdy32);
    end
  endtask

  task automatic test_vectors();
    bq_t f;
    f = frame_123();
    send_frame(f, 1'b0, 1'b0);
    checks++;
    if (value32 !== 32'hCBF43926 || value16 !== 16'h29B1) begin
      errors++; $display("FAIL vector_123: crc32 %08h crc16 %04h required CBF43926 29B1", value32, value16);
    end
    check_and_pop(f, "vec123");
  endtask

  task automatic test_check_mode();
    bq_t f;
    int  bi;
    f = frame_123();
    f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
    send_frame(f, 1'b0, 1'b0);
    checks++;
    if (okck !== 1'b1 || valueck !== 32'h2144DF1C) begin
      errors++; $display("FAIL check_good: ok=%0b value=%08h required 1 2144DF1C", okck, valueck);
    end
    check_and_pop(f, "check_good");
    bi = $urandom_range(0, 8*f.size() - 1);
    f[bi/8][bi%8] = ~f[bi/8][bi%8];
    send_frame(f, 1'b0, 1'b0);
    checks++;
    if (okck !== 1'b0) begin
      errors++; $display("FAIL check_bad: ok=%0b after bit %0d flip, required 0", okck, bi);
    end
    check_and_pop(f, "check_bad");
  endtask

  task automatic test_backpressure();
    bq_t f;
    f = frame_123();
    send_frame(f, 1'b0, 1'b0);
    // The first beat of the next frame is offered while the result waits.
    in_valid = 1'b1; in_data = 32'h34333231; in_keep = 4'hF; in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (val32 !== 1'b1 || value32 !== 32'hCBF43926 || rdy32 !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d: valid=%0b value=%08h ready=%0b required 1 CBF43926 0",
                 c, val32, value32, rdy32);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_and_pop(f, "bp_first");
    send_frame(f, 1'b0, 1'b0);
    checks++;
    if (value32 !== 32'hCBF43926) begin
      errors++; $display("FAIL bp_second: got %08h required CBF43926", value32);
    end
    check_and_pop(f, "bp_second");
  endtask

  task automatic test_random_bubbles();
    bq_t f;
    for (int t = 0; t < 12; t++) begin
      f = {};
      // Even trials: 12 bytes closed by an empty last beat.
      // Odd trials: random length 1..21.
      if (t % 2 == 0) begin
        for (int i = 0; i < 12; i++) f.push_back(8'($urandom));
        send_frame(f, 1'b1, 1'b1);
      end else begin
        for (int i = 0; i < int'($urandom_range(1, 21)); i++) f.push_back(8'($urandom));
        send_frame(f, 1'b1, 1'b0);
      end
      check_and_pop(f, $sformatf("rand%0d", t));
    end
  endtask

  task automatic test_reset_midframe();
    bq_t f;
    f = frame_123();
    drive_beat(32'h34333231, 4'hF, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (val32 !== 1'b0 || rdy32 !== 1'b1) begin
      errors++; $display("FAIL rst_mid: valid=%0b ready=%0b required 0 1", val32, rdy32);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (val32 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: valid=%0b required 0", val32);
    end
    send_frame(f, 1'b0, 1'b0);
    checks++;
    if (value32 !== 32'hCBF43926) begin
      errors++; $display("FAIL rst_resend: got %08h required CBF43926", value32);
    end
    // Reset while the result is pending discards it at once.
    reset = 1'b1;
    #1;
    checks++;
    if (val32 !== 1'b0 || value32 !== 32'h0) begin
      errors++; $display("FAIL rst_done: valid=%0b value=%08h required 0 00000000", val32, value32);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    send_frame(f, 1'b0, 1'b0);
    check_and_pop(f, "after_rst");
  endtask

  initial begin
    #1;
    test_reset();
    test_vectors();
    test_check_mode();
    test_backpressure();
    test_random_bubbles();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
